// File: rtl/mb_pkg.sv
// Shared definitions for the PCI master burst engine: FSM encoding, bus command
// code and the core status (csr) bit positions that drive termination handling.
package mb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_REQ,
    ST_XFER,
    ST_RTY,
    ST_DONE,
    ST_ERR
  } mb_state_e;

  // Upper three command bits; the low bit is the transfer direction.
  localparam logic [2:0] MB_CMD_CODE = 3'b011;

  localparam int CSR_FATAL_A = 39;
  localparam int CSR_FATAL_B = 38;
  localparam int CSR_RETRY   = 36;

  // Words that must be buffered before a write burst may be requested.
  function automatic logic [31:0] burst_need(input logic [31:0] remaining,
                                             input logic [31:0] depth);
    return (remaining > depth) ? depth : remaining;
  endfunction

endpackage

// File: rtl/mb_sync_fifo.sv
// Single-clock write-data FIFO (power-of-two depth) with occupancy count and
// a synchronous flush used to discard buffered data after a fatal termination.
module mb_sync_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  logic [31:0]            din,
  output logic [31:0]            dout,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = DEPTH[AW:0];

  logic [31:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  assign full    = (count_q == DEPTH_C);
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign dout    = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    count_d  = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset so it can map onto distributed RAM.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/master_burst_engine.sv
// Descriptor-driven PCI master burst engine. Optional build macro
// MB_RETRY_LIMIT_EN aborts a descriptor after 16 consecutive target retries.
module master_burst_engine
  import mb_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int LEN_W      = 8
) (
  input  logic             CLK,
  input  logic             reset_n,
  input  logic             desc_valid,
  output logic             desc_ready,
  input  logic [29:0]      desc_addr,
  input  logic [LEN_W-1:0] desc_len,
  input  logic             desc_dir,
  input  logic [31:0]      wr_data,
  input  logic             wr_valid,
  output logic             wr_ready,
  output logic [31:0]      rd_data,
  output logic             rd_valid,
  output logic             done,
  output logic             err,
  input  logic [31:0]      adio_out,
  output logic [31:0]      adio_in,
  input  logic             m_data,
  input  logic             m_data_vld,
  input  logic             m_addr_n,
  input  logic             m_src_en,
  input  logic [39:0]      csr,
  output logic             request,
  output logic             requesthold,
  output logic             complete,
  output logic             m_ready,
  output logic             m_wrdn,
  output logic [3:0]       m_cbe
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  mb_state_e        state_q, state_d;
  logic [29:0]      addr_q, addr_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic             dir_q, dir_d;
  logic             fatal_q, fatal_d;
  logic             retry_q, retry_d;
  logic             m_data_q;
  logic [31:0]      rd_data_q, rd_data_d;
  logic             rd_valid_q, rd_valid_d;
  logic             m_ready_q;

  logic             fifo_push, fifo_pop, fifo_flush, fifo_full, fifo_empty;
  logic [31:0]      fifo_head;
  logic [CW-1:0]    fifo_count;
  logic             xfer_end, burst_ready, retry_limit_hit;
  logic             unused_csr;

  assign unused_csr = ^{csr[37], csr[35:0]};

  mb_sync_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (CLK),
    .rst_n (reset_n),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .flush (fifo_flush),
    .din   (wr_data),
    .dout  (fifo_head),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign wr_ready    = !fifo_full;
  assign fifo_push   = wr_valid && !fifo_full;
  assign xfer_end    = m_data_q && !m_data;
  assign burst_ready = !dir_q ||
                       (32'(fifo_count) >= burst_need(32'(rem_q), 32'(FIFO_DEPTH)));

`ifdef MB_RETRY_LIMIT_EN
  logic [3:0] rty_cnt_q, rty_cnt_d;

  assign retry_limit_hit = (rty_cnt_q == 4'hF);

  always_comb begin
    rty_cnt_d = rty_cnt_q;
    if (m_data_vld)
      rty_cnt_d = '0;
    else if (state_q == ST_XFER && xfer_end && !fatal_q && retry_q)
      rty_cnt_d = rty_cnt_q + 4'd1;
  end

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) rty_cnt_q <= '0;
    else          rty_cnt_q <= rty_cnt_d;
  end
`else
  assign retry_limit_hit = 1'b0;
`endif

  // m_ready_q doubles as "out of reset" so desc_ready stays low during reset.
  assign m_ready     = m_ready_q;
  assign desc_ready  = (state_q == ST_IDLE) && m_ready_q;
  assign m_wrdn      = dir_q;
  assign requesthold = 1'b0;
  assign rd_data     = rd_data_q;
  assign rd_valid    = rd_valid_q;
  assign m_cbe       = !m_addr_n ? {MB_CMD_CODE, dir_q} : 4'b0000;
  assign adio_in     = !m_addr_n            ? {addr_q, 2'b00} :
                       (m_src_en && dir_q)  ? fifo_head       : 32'h0;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    rem_d      = rem_q;
    dir_d      = dir_q;
    fatal_d    = fatal_q;
    retry_d    = retry_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    request    = 1'b0;
    complete   = 1'b0;
    done       = 1'b0;
    err        = 1'b0;
    fifo_pop   = 1'b0;
    fifo_flush = 1'b0;

    // Termination status is collected over the data phase and consumed when m_data drops.
    if (!m_addr_n) begin
      fatal_d = 1'b0;
      retry_d = 1'b0;
    end else if (m_data) begin
      fatal_d = fatal_q | csr[CSR_FATAL_A] | csr[CSR_FATAL_B];
      retry_d = retry_q | csr[CSR_RETRY];
    end

    case (state_q)
      ST_IDLE: begin
        if (desc_valid && m_ready_q) begin
          addr_d  = desc_addr;
          rem_d   = desc_len;
          dir_d   = desc_dir;
          state_d = (desc_len == '0) ? ST_DONE : ST_WAIT;
        end
      end
      ST_WAIT: if (burst_ready) state_d = ST_REQ;
      ST_REQ: begin
        request = 1'b1;
        state_d = ST_XFER;
      end
      ST_XFER: begin
        complete = (rem_q <= LEN_W'(1));
        if (m_data_vld) begin
          addr_d = addr_q + 30'd1;
          rem_d  = rem_q - LEN_W'(1);
          if (dir_q) begin
            fifo_pop = !fifo_empty;
          end else begin
            rd_valid_d = 1'b1;
            rd_data_d  = adio_out;
          end
        end
        if (xfer_end) begin
          if (fatal_q)              state_d = ST_ERR;
          else if (retry_q)         state_d = retry_limit_hit ? ST_ERR : ST_RTY;
          else if (rem_q == '0)     state_d = ST_DONE;
          else                      state_d = ST_REQ;
        end
      end
      ST_RTY:  state_d = ST_WAIT;
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      ST_ERR: begin
        err        = 1'b1;
        fifo_flush = 1'b1;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      rem_q      <= '0;
      dir_q      <= 1'b0;
      fatal_q    <= 1'b0;
      retry_q    <= 1'b0;
      m_data_q   <= 1'b0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      m_ready_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      rem_q      <= rem_d;
      dir_q      <= dir_d;
      fatal_q    <= fatal_d;
      retry_q    <= retry_d;
      m_data_q   <= m_data;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      m_ready_q  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_master_burst_engine.sv
// Directed bench for master_burst_engine: a small PCI core model drives address
// and data phases while each scenario task checks outputs against hand-derived values.
module tb_master_burst_engine;

  logic        CLK = 1'b0;
  logic        reset_n;
  logic        desc_valid;
  logic        desc_ready;
  logic [29:0] desc_addr;
  logic [7:0]  desc_len;
  logic        desc_dir;
  logic [31:0] wr_data;
  logic        wr_valid;
  logic        wr_ready;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic        done;
  logic        err;
  logic [31:0] adio_out;
  logic [31:0] adio_in;
  logic        m_data, m_data_vld, m_addr_n, m_src_en;
  logic [39:0] csr;
  logic        request, requesthold, complete, m_ready, m_wrdn;
  logic [3:0]  m_cbe;

  localparam logic [39:0] CSR_RETRY = 40'h10_0000_0000;
  localparam logic [39:0] CSR_FATAL = 40'h80_0000_0000;

  int checks = 0;
  int passed = 0;

  int done_total = 0;
  int err_total  = 0;
  int req_total  = 0;
  logic [31:0] rd_got[$];
  logic [31:0] rd_src[$];
  logic [31:0] wr_seen[$];
  logic [31:0] last_addr;
  logic [3:0]  last_cbe;
  logic [15:0] compl_bits;

  master_burst_engine #(.FIFO_DEPTH(16), .LEN_W(8)) dut (
    .CLK(CLK), .reset_n(reset_n),
    .desc_valid(desc_valid), .desc_ready(desc_ready), .desc_addr(desc_addr),
    .desc_len(desc_len), .desc_dir(desc_dir),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_valid(rd_valid), .done(done), .err(err),
    .adio_out(adio_out), .adio_in(adio_in),
    .m_data(m_data), .m_data_vld(m_data_vld), .m_addr_n(m_addr_n), .m_src_en(m_src_en),
    .csr(csr), .request(request), .requesthold(requesthold), .complete(complete),
    .m_ready(m_ready), .m_wrdn(m_wrdn), .m_cbe(m_cbe)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK) begin
    if (done)     done_total++;
    if (err)      err_total++;
    if (request)  req_total++;
    if (rd_valid) rd_got.push_back(rd_data);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic push_word(input logic [31:0] v);
    wr_valid = 1'b1;
    wr_data  = v;
    tick;
    wr_valid = 1'b0;
  endtask

  task automatic submit(input logic [29:0] a, input logic [7:0] l, input logic d, input string tag);
    desc_valid = 1'b1;
    desc_addr  = a;
    desc_len   = l;
    desc_dir   = d;
    #1;
    checks++;
    if (desc_ready !== 1'b1) $display("FAIL %s_desc_ready: got %b want 1", tag, desc_ready);
    else passed++;
    tick;
    desc_valid = 1'b0;
  endtask

  task automatic wait_request(input string tag);
    bit seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (request === 1'b1) seen = 1;
      else tick;
    end
    checks++;
    if (!seen) $display("FAIL %s_request: got none within 40 cycles want 1 pulse", tag);
    else passed++;
  endtask

  // One core transaction: address phase, nwords data phases (or a single
  // data-less phase when nwords is 0), end_csr presented on the last phase.
  task automatic pci_txn(input int nwords, input logic [39:0] end_csr);
    tick;
    m_addr_n = 1'b0;
    #1;
    last_addr = adio_in;
    last_cbe  = m_cbe;
    tick;
    m_addr_n   = 1'b1;
    compl_bits = '0;
    for (int k = 0; k < nwords; k++) begin
      m_data     = 1'b1;
      m_data_vld = 1'b1;
      m_src_en   = m_wrdn;
      if (rd_src.size() > 0) adio_out = rd_src.pop_front();
      else adio_out = '0;
      if (k == nwords - 1) csr = end_csr;
      #1;
      if (m_wrdn) wr_seen.push_back(adio_in);
      compl_bits[k] = complete;
      tick;
    end
    if (nwords == 0) begin
      m_data = 1'b1;
      csr    = end_csr;
      tick;
    end
    m_data     = 1'b0;
    m_data_vld = 1'b0;
    m_src_en   = 1'b0;
    csr        = '0;
    adio_out   = '0;
    tick;
    $display("txn: words=%0d addr=%h cbe=%b csr=%h", nwords, last_addr, last_cbe, end_csr);
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    desc_valid = 0; desc_addr = '0; desc_len = '0; desc_dir = 0;
    wr_data = '0; wr_valid = 0; adio_out = '0;
    m_data = 0; m_data_vld = 0; m_addr_n = 1; m_src_en = 0; csr = '0;
    repeat (3) @(posedge CLK);
    #1;
    checks++;
    if ({desc_ready, request, complete, done, err, rd_valid, m_ready, m_wrdn, requesthold} !== 9'b0)
      $display("FAIL reset_ctrl: got %b want 000000000",
               {desc_ready, request, complete, done, err, rd_valid, m_ready, m_wrdn, requesthold});
    else passed++;
    checks++;
    if (wr_ready !== 1'b1) $display("FAIL reset_wr_ready: got %b want 1", wr_ready); else passed++;
    checks++;
    if ({adio_in, m_cbe, rd_data} !== 68'h0) $display("FAIL reset_buses: got adio_in=%h m_cbe=%b rd_data=%h want 0", adio_in, m_cbe, rd_data);
    else passed++;
    reset_n = 1'b1;
    tick;
    checks++;
    if (m_ready !== 1'b1) $display("FAIL reset_m_ready_after: got %b want 1", m_ready); else passed++;
    checks++;
    if (desc_ready !== 1'b1) $display("FAIL reset_desc_ready_after: got %b want 1", desc_ready); else passed++;
  endtask

  task automatic test_write;
    int d0 = done_total;
    int r0 = req_total;
    wr_seen.delete();
    for (int v = 1; v <= 4; v++) push_word(32'(v));
    submit(30'h400, 8'd4, 1'b1, "write");
    wait_request("write");
    pci_txn(4, '0);
    checks++;
    if (last_addr !== 32'h1000) $display("FAIL write_addr_phase: got %h want 00001000", last_addr); else passed++;
    checks++;
    if (last_cbe !== 4'b0111) $display("FAIL write_cbe: got %b want 0111", last_cbe); else passed++;
    checks++;
    if (wr_seen.size() != 4) $display("FAIL write_nwords: got %0d want 4", wr_seen.size()); else passed++;
    for (int k = 0; k < 4 && k < wr_seen.size(); k++) begin
      checks++;
      if (wr_seen[k] !== 32'(k + 1)) $display("FAIL write_data%0d: got %h want %h", k, wr_seen[k], k + 1);
      else passed++;
    end
    checks++;
    if (compl_bits[3:0] !== 4'b1000) $display("FAIL write_complete: got %b want 1000", compl_bits[3:0]); else passed++;
    checks++;
    if (done !== 1'b1) $display("FAIL write_done_now: got %b want 1", done); else passed++;
    tick;
    checks++;
    if (done_total - d0 != 1) $display("FAIL write_done_count: got %0d want 1", done_total - d0); else passed++;
    checks++;
    if (req_total - r0 != 1) $display("FAIL write_req_count: got %0d want 1", req_total - r0); else passed++;
  endtask

  task automatic test_read;
    int d0 = done_total;
    rd_got.delete();
    rd_src.delete();
    rd_src.push_back(32'hA5A5A5A5);
    rd_src.push_back(32'h5A5A5A5A);
    submit(30'h800, 8'd2, 1'b0, "read");
    wait_request("read");
    pci_txn(2, '0);
    checks++;
    if (last_addr !== 32'h2000) $display("FAIL read_addr_phase: got %h want 00002000", last_addr); else passed++;
    checks++;
    if (last_cbe !== 4'b0110) $display("FAIL read_cbe: got %b want 0110", last_cbe); else passed++;
    checks++;
    if (done !== 1'b1) $display("FAIL read_done_now: got %b want 1", done); else passed++;
    tick;
    checks++;
    if (rd_got.size() != 2) $display("FAIL read_strobes: got %0d want 2", rd_got.size()); else passed++;
    if (rd_got.size() == 2) begin
      checks++;
      if (rd_got[0] !== 32'hA5A5A5A5) $display("FAIL read_data0: got %h want a5a5a5a5", rd_got[0]); else passed++;
      checks++;
      if (rd_got[1] !== 32'h5A5A5A5A) $display("FAIL read_data1: got %h want 5a5a5a5a", rd_got[1]); else passed++;
    end
    checks++;
    if (done_total - d0 != 1) $display("FAIL read_done_count: got %0d want 1", done_total - d0); else passed++;
  endtask

  task automatic test_retry;
    int d0 = done_total;
    int r0 = req_total;
    wr_seen.delete();
    for (int v = 1; v <= 4; v++) push_word(32'(v));
    submit(30'h400, 8'd4, 1'b1, "retry");
    wait_request("retry_first");
    pci_txn(2, CSR_RETRY);
    checks++;
    if ({done, err} !== 2'b00) $display("FAIL retry_no_end: got done/err=%b want 00", {done, err}); else passed++;
    wait_request("retry_second");
    pci_txn(2, '0);
    checks++;
    if (last_addr !== 32'h1008) $display("FAIL retry_resume_addr: got %h want 00001008", last_addr); else passed++;
    checks++;
    if (wr_seen.size() != 4) $display("FAIL retry_total_pops: got %0d want 4", wr_seen.size()); else passed++;
    for (int k = 0; k < 4 && k < wr_seen.size(); k++) begin
      checks++;
      if (wr_seen[k] !== 32'(k + 1)) $display("FAIL retry_data%0d: got %h want %h", k, wr_seen[k], k + 1);
      else passed++;
    end
    checks++;
    if (compl_bits[1:0] !== 2'b10) $display("FAIL retry_complete: got %b want 10", compl_bits[1:0]); else passed++;
    tick;
    checks++;
    if (req_total - r0 != 2) $display("FAIL retry_req_count: got %0d want 2", req_total - r0); else passed++;
    checks++;
    if (done_total - d0 != 1) $display("FAIL retry_done_count: got %0d want 1", done_total - d0); else passed++;
  endtask

  task automatic fill_and_check(input string tag);
    for (int i = 0; i < 16; i++) begin
      push_word(32'(200 + i));
      if (i == 14) begin
        checks++;
        if (wr_ready !== 1'b1) $display("FAIL %s_15_words: wr_ready got %b want 1", tag, wr_ready); else passed++;
      end
    end
    checks++;
    if (wr_ready !== 1'b0) $display("FAIL %s_16_words: wr_ready got %b want 0", tag, wr_ready); else passed++;
  endtask

  task automatic test_fatal_flush;
    int d0, e0;
    fill_and_check("fill_before_fatal");
    d0 = done_total;
    e0 = err_total;
    rd_src.delete();
    rd_src.push_back(32'h11);
    submit(30'h800, 8'd4, 1'b0, "fatal");
    wait_request("fatal");
    pci_txn(1, CSR_FATAL);
    checks++;
    if ({err, done} !== 2'b10) $display("FAIL fatal_pulse_now: got err/done=%b want 10", {err, done}); else passed++;
    tick;
    checks++;
    if (err_total - e0 != 1) $display("FAIL fatal_err_count: got %0d want 1", err_total - e0); else passed++;
    checks++;
    if (done_total != d0) $display("FAIL fatal_no_done: got %0d want 0", done_total - d0); else passed++;
    checks++;
    if (desc_ready !== 1'b1) $display("FAIL fatal_idle: desc_ready got %b want 1", desc_ready); else passed++;
    fill_and_check("fill_after_fatal");
  endtask

  task automatic test_retry_limit;
    int d0 = done_total;
    int e0 = err_total;
    int r0 = req_total;
    rd_got.delete();
    rd_src.delete();
    submit(30'h800, 8'd1, 1'b0, "limit");
`ifdef MB_RETRY_LIMIT_EN
    for (int r = 0; r < 16; r++) begin
      wait_request("limit");
      pci_txn(0, CSR_RETRY);
      if (r == 14) begin
        checks++;
        if (err_total != e0) $display("FAIL limit_early_err: got %0d errs want 0 after 15 retries", err_total - e0); else passed++;
      end
    end
    checks++;
    if (err !== 1'b1) $display("FAIL limit_err_now: got %b want 1", err); else passed++;
    tick;
    checks++;
    if (err_total - e0 != 1) $display("FAIL limit_err_count: got %0d want 1", err_total - e0); else passed++;
    checks++;
    if (req_total - r0 != 16) $display("FAIL limit_req_count: got %0d want 16", req_total - r0); else passed++;
    checks++;
    if (done_total != d0) $display("FAIL limit_no_done: got %0d want 0", done_total - d0); else passed++;
`else
    for (int r = 0; r < 20; r++) begin
      wait_request("limit");
      pci_txn(0, CSR_RETRY);
    end
    checks++;
    if (err_total != e0) $display("FAIL limit_no_err: got %0d want 0", err_total - e0); else passed++;
    rd_src.push_back(32'hCAFEF00D);
    wait_request("limit_final");
    pci_txn(1, '0);
    checks++;
    if (last_addr !== 32'h2000) $display("FAIL limit_addr_kept: got %h want 00002000", last_addr); else passed++;
    checks++;
    if (done !== 1'b1) $display("FAIL limit_done_now: got %b want 1", done); else passed++;
    tick;
    checks++;
    if (req_total - r0 != 21) $display("FAIL limit_req_count: got %0d want 21", req_total - r0); else passed++;
    checks++;
    if (rd_got.size() != 1 || rd_got[0] !== 32'hCAFEF00D)
      $display("FAIL limit_read_data: got %0d strobes first=%h want 1 strobe cafef00d", rd_got.size(),
               (rd_got.size() > 0) ? rd_got[0] : 32'h0);
    else passed++;
`endif
    rd_src.delete();
  endtask

  task automatic test_midxfer_reset;
    int d0, e0, r0;
    for (int i = 0; i < 20; i++) if (wr_ready) push_word(32'(300 + i));
    checks++;
    if (wr_ready !== 1'b0) $display("FAIL midreset_prefill: wr_ready got %b want 0", wr_ready); else passed++;
    d0 = done_total;
    e0 = err_total;
    submit(30'h400, 8'd4, 1'b1, "midreset");
    wait_request("midreset");
    tick;
    m_addr_n = 1'b0;
    tick;
    m_addr_n   = 1'b1;
    m_data     = 1'b1;
    m_data_vld = 1'b1;
    m_src_en   = 1'b1;
    tick;
    checks++;
    if ({m_wrdn, complete} !== 2'b10) $display("FAIL midreset_in_xfer: wrdn/complete got %b want 10", {m_wrdn, complete}); else passed++;
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({desc_ready, request, complete, done, err, rd_valid, m_ready, m_wrdn} !== 8'b0)
      $display("FAIL midreset_ctrl: got %b want 00000000",
               {desc_ready, request, complete, done, err, rd_valid, m_ready, m_wrdn});
    else passed++;
    checks++;
    if ({adio_in, m_cbe} !== 36'h0) $display("FAIL midreset_buses: got adio_in=%h m_cbe=%b want 0", adio_in, m_cbe); else passed++;
    checks++;
    if (wr_ready !== 1'b1) $display("FAIL midreset_fifo_empty: wr_ready got %b want 1", wr_ready); else passed++;
    m_data = 0; m_data_vld = 0; m_src_en = 0;
    repeat (2) @(posedge CLK);
    #3;
    reset_n = 1'b1;
    tick;
    tick;
    checks++;
    if (done_total != d0 || err_total != e0)
      $display("FAIL midreset_no_pulse: got done=%0d err=%0d want 0 0", done_total - d0, err_total - e0);
    else passed++;
    r0 = req_total;
    submit(30'h10, 8'd0, 1'b1, "zero_len");
    checks++;
    if (done !== 1'b1) $display("FAIL zero_len_done: got %b want 1", done); else passed++;
    tick;
    checks++;
    if (req_total != r0) $display("FAIL zero_len_no_request: got %0d want 0", req_total - r0); else passed++;
    checks++;
    if (desc_ready !== 1'b1) $display("FAIL zero_len_idle: desc_ready got %b want 1", desc_ready); else passed++;
  endtask

  initial begin
    test_reset;
    test_write;
    test_read;
    test_retry;
    test_fatal_flush;
    test_retry_limit;
    test_midxfer_reset;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/master_burst_engine.md
MASTER_BURST_ENGINE -- requirements
Module: master_burst_engine

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 16, meaning write-data FIFO depth in 32-bit words (power of 2, 4..64).
REQ-002 SHALL have parameter LEN_W, default 8, meaning width of the descriptor word count.
REQ-003 Ports (name  direction  width  meaning):
CLK  in  1  sole clock; all state on rising edge
reset_n  in  1  asynchronous active-low reset
desc_valid  in  1  descriptor offered
desc_ready  out  1  descriptor accepted when both high
desc_addr  in  30  word address [31:2]
desc_len  in  LEN_W  word count
desc_dir  in  1  1=write, 0=read
wr_data  in  32  write payload
wr_valid  in  1  payload offered
wr_ready  out  1  FIFO not full
rd_data  out  32  read payload
rd_valid  out  1  one-cycle strobe, no backpressure
done  out  1  one-cycle pulse, descriptor finished
err  out  1  one-cycle pulse, fatal termination
adio_out  in  32  core data bus from PCI
adio_in  out  32  core data bus to PCI
m_data, m_data_vld, m_addr_n, m_src_en  in  1 each  core master status
csr  in  40  core status
request, requesthold, complete, m_ready, m_wrdn  out  1 each  core master controls
m_cbe  out  4  command / byte enables
REQ-004 Clocking SHALL be one clock, CLK; reset SHALL be asynchronous and active-low, reset_n.

Function
REQ-005 States SHALL be IDLE, WAIT, REQ, XFER, RTY, DONE, ERR.
REQ-006 desc_ready SHALL be high only in IDLE; acceptance latches addr, len, dir; desc_len=0 goes directly to DONE without request.
REQ-007 IDLE->WAIT on acceptance; WAIT->REQ when dir=0, or when FIFO count >= min(remaining, FIFO_DEPTH) for dir=1.
REQ-008 request SHALL be high exactly one cycle in REQ; REQ->XFER next cycle.
REQ-009 fatal SHALL be latched as csr[39]|csr[38], retry as csr[36], while m_data high; both cleared when m_addr_n low.
REQ-010 XFER on m_data falling edge: fatal->ERR, else retry->RTY, else remaining=0->DONE, else REQ (core disconnect, resume).
REQ-011 RTY->WAIT after one cycle; address and remaining SHALL be unchanged by retry except for words already counted.
REQ-012 Each m_data_vld in XFER SHALL increment the word address by 1 (wraps modulo 2^30) and decrement remaining.
REQ-013 complete SHALL be high in XFER when remaining<=1.
REQ-014 adio_in SHALL be {addr,2'b00} while m_addr_n low; FIFO head when m_src_en high and dir=1; else 0.
REQ-015 m_cbe SHALL be {3'b011,dir} while m_addr_n low, else 4'b0000; m_wrdn=dir; requesthold=0.
REQ-016 FIFO pop SHALL occur only on m_data_vld with dir=1; push on wr_valid&wr_ready; simultaneous push/pop keeps count.
REQ-017 Read: rd_data<=adio_out and rd_valid=1 one cycle after m_data_vld with dir=0.
REQ-018 DONE->IDLE pulsing done; ERR->IDLE pulsing err and flushing FIFO.
REQ-019 m_ready SHALL be 0 in reset, 1 thereafter.

Reset
REQ-020 On reset_n low: state IDLE, FIFO empty, all outputs 0 except wr_ready=1; mid-transfer reset abandons transfer with no done/err.

Configuration
REQ-021 Macro MB_RETRY_LIMIT_EN: defined -> 4-bit consecutive-retry counter, 16th retry goes to ERR; counter clears on any m_data_vld. Undefined -> retries unlimited, no counter.

Structure
REQ-022 Package mb_pkg SHALL hold state encoding, command code 3'b011, csr bit indices 36/38/39.
REQ-023 FIFO SHALL be sub-module mb_sync_fifo (push/pop/count/full/empty).

Verification
REQ-024 Write addr 0x1000, len 4, data 1..4 preloaded -> one request, adio_in 0x1000 in addr phase, 1..4 in data phases, done once.
REQ-025 Read addr 0x2000, len 2, adio_out 0xA5A5A5A5, 0x5A5A5A5A -> two rd_valid strobes with those values, done.
REQ-026 Write len 4, retry after 2 words -> RTY, second request at 0x1008 for 2 words, total 4 pops.
REQ-027 csr[39] during read -> err pulse, IDLE, no done, FIFO empty.
REQ-028 MB_RETRY_LIMIT_EN, 16 back-to-back retries -> err; undefined -> 20 retries, then success -> done.
REQ-029 reset_n low mid-XFER -> all outputs reset values asynchronously, new descriptor accepted after release.
